uart_rx_buffer: RTL and testbench

//  Downstream stage of the UART receiver. Takes each completed 8-bit frame plus its received

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_rx_buffer.sv | 76 +++++++
 tb/tb_uart_rx_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path types: the queued entry format and the parity-sense constants.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef struct packed {
        uart_byte_t data;
        logic       perr;
    } uart_rx_entry_t;

    localparam bit UART_PARITY_EVEN = 1'b0;
    localparam bit UART_PARITY_ODD  = 1'b1;

    // True when the byte plus its received parity bit does not match the expected sense.
    function automatic logic parity_error(input uart_byte_t data, input logic parity, input bit odd);
        return (^{data, parity}) != odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with show-ahead read data, occupancy count and full/empty flags.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count define what is valid,
    // so leaving it unreset keeps it a plain RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: parity-checks each completed frame, queues {byte, perr} and
// hands entries to the consumer over valid/ready, flagging frames lost to a full queue.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter bit PARITY_ODD = UART_PARITY_EVEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_parity,
    input  logic                   rx_valid,
    output logic [7:0]             out_data,
    output logic                   out_perr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    uart_rx_entry_t in_entry;
    uart_rx_entry_t head_entry;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           drop;

    assign in_entry.data = rx_data;
    assign in_entry.perr = parity_error(rx_data, rx_parity, PARITY_ODD);

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = rx_valid && (!fifo_full || pop);
    assign drop      = rx_valid && fifo_full && !pop;

    uart_sync_fifo #(
        .WIDTH ($bits(uart_rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_entry),
        .rd_data (head_entry),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // NOTE: every output of this block gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        out_data = '0;
        out_perr = 1'b0;
        if (!fifo_empty) begin
            out_data = head_entry.data;
            out_perr = head_entry.perr;
        end
    end

    // A dropped frame wins over a clear in the same cycle so no loss goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: a queue-based model checked every cycle,
// plus directed scenarios with hand-computed expectations (even and odd parity builds).
module tb_uart_rx_buffer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_parity = 1'b0;
    logic       rx_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       overrun_clr = 1'b0;

    logic [7:0] out_data,  out_data_o;
    logic       out_perr,  out_perr_o;
    logic       out_valid, out_valid_o;
    logic [3:0] count,     count_o;
    logic       overrun,   overrun_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_buffer #(.DEPTH(DEPTH), .PARITY_ODD(1'b0)) dut (
        .clk (clk), .reset (reset),
        .rx_data (rx_data), .rx_parity (rx_parity), .rx_valid (rx_valid),
        .out_data (out_data), .out_perr (out_perr), .out_valid (out_valid), .out_ready (out_ready),
        .count (count), .overrun (overrun), .overrun_clr (overrun_clr)
    );

    uart_rx_buffer #(.DEPTH(DEPTH), .PARITY_ODD(1'b1)) dut_odd (
        .clk (clk), .reset (reset),
        .rx_data (rx_data), .rx_parity (rx_parity), .rx_valid (rx_valid),
        .out_data (out_data_o), .out_perr (out_perr_o), .out_valid (out_valid_o), .out_ready (out_ready),
        .count (count_o), .overrun (overrun_o), .overrun_clr (overrun_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of raw {byte, parity bit}; parity errors derived from the rule at read time.
    logic [8:0] model_q[$];
    logic       model_ovr = 1'b0;
    bit         model_live = 1'b0;

    always @(posedge clk) begin
        bit pop_now;
        bit full_now;
        bit dropped;
        if (reset) begin
            model_q.delete();
            model_ovr = 1'b0;
            model_live = 1'b1;
        end else begin
            pop_now  = (model_q.size() > 0) && out_ready;
            full_now = (model_q.size() == DEPTH);
            dropped  = rx_valid && full_now && !pop_now;
            if (pop_now) void'(model_q.pop_front());
            if (rx_valid && !dropped) model_q.push_back({rx_data, rx_parity});
            if (dropped) model_ovr = 1'b1;
            else if (overrun_clr) model_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [8:0] h;
        bit         v;
        if (model_live) begin
            v = (model_q.size() != 0);
            h = v ? model_q[0] : 9'h000;
            check("cmp_valid",    out_valid,   v);
            check("cmp_count",    count,       model_q.size());
            check("cmp_data",     out_data,    v ? h[8:1] : 8'h00);
            check("cmp_perr",     out_perr,    v && ((^h) != 1'b0));
            check("cmp_overrun",  overrun,     model_ovr);
            check("cmp_valid_o",  out_valid_o, v);
            check("cmp_count_o",  count_o,     model_q.size());
            check("cmp_data_o",   out_data_o,  v ? h[8:1] : 8'h00);
            check("cmp_perr_o",   out_perr_o,  v && ((^h) != 1'b1));
            check("cmp_overrun_o", overrun_o,  model_ovr);
        end
    end

    task automatic step(input logic rv, input logic [7:0] d, input logic p,
                        input logic rdy, input logic oc, input logic rst);
        @(negedge clk);
        rx_valid    = rv;
        rx_data     = d;
        rx_parity   = p;
        out_ready   = rdy;
        overrun_clr = oc;
        reset       = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        step(1'b1, d, p, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_valid",   out_valid, 0);
        check("rst_count",   count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data",    out_data, 8'h00);

        // 1: single entry, one-cycle latency, then drain
        push(8'hA5, 1'b0);
        check("t1_valid", out_valid, 1);
        check("t1_data",  out_data, 8'hA5);
        check("t1_perr",  out_perr, 0);
        check("t1_count", count, 1);
        pop1();
        check("t1_empty", out_valid, 0);
        check("t1_count0", count, 0);
        check("t1_data0", out_data, 8'h00);

        // 2: parity sense
        push(8'h01, 1'b0);
        check("t2_perr_even", out_perr, 1);
        check("t2_perr_odd",  out_perr_o, 0);
        pop1();

        // 3: fill, overrun on drop, ordered drain, clear
        for (int i = 0; i < 8; i++) push(8'(i), 1'(i % 2));
        check("t3_full", count, 8);
        push(8'h08, 1'b1);
        check("t3_overrun", overrun, 1);
        check("t3_count", count, 8);
        for (int i = 0; i < 8; i++) begin
            check("t3_order", out_data, 32'(i));
            pop1();
        end
        check("t3_drained", count, 0);
        check("t3_sticky", overrun, 1);
        clr();
        check("t3_cleared", overrun, 0);

        // 4: push+pop while full, then pointer wrap
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_count", count, 8);
        check("t4_overrun", overrun, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t4_last55", out_data, 8'h55);
            pop1();
        end
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 1'b1);
        for (int k = 0; k < 20; k++) step(1'b1, 8'h60 + 8'(k), 1'(k % 3 == 0), 1'b1, 1'b0, 1'b0);
        check("t4_wrap_head", out_data, 8'h6C);
        check("t4_wrap_count", count, 8);
        for (int i = 0; i < 8; i++) pop1();

        // 5: reset mid-stream
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 1'b0);
        push(8'hF0, 1'b0);
        for (int i = 0; i < 3; i++) pop1();
        check("t5_count5", count, 5);
        check("t5_ovr_pre", overrun, 1);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t5_count", count, 0);
        check("t5_valid", out_valid, 0);
        check("t5_overrun", overrun, 0);
        push(8'h3C, 1'b0);
        check("t5_head", out_data, 8'h3C);
        check("t5_count1", count, 1);
        pop1();

        // 6: set beats clear; reads from empty are harmless
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i), 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_set_wins", overrun, 1);
        check("t6_count", count, 8);
        for (int i = 0; i < 8; i++) pop1();
        clr();
        check("t6_cleared", overrun, 0);
        for (int i = 0; i < 3; i++) begin
            pop1();
            check("t6_empty_count", count, 0);
            check("t6_empty_valid", out_valid, 0);
        end
        push(8'h77, 1'b1);
        check("t6_head", out_data, 8'h77);
        check("t6_count1", count, 1);
        pop1();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
